multi_ch_read_requester: RTL and testbench

- Parametrised N-channel successor to the single-FIFO hysteresis read requester.
- Watches per-channel programmable full/empty flags and keeps one pending flag per channel.
- Grants exactly one channel at a time (round-robin) to the shared downstream reader in the SFP_IF datapath.
- Optional starvation timeout drains channels holding partial data below the programmable-full threshold.

---
 rtl/multi_ch_read_requester.sv | 207 ++++++++++++++++++++
 tb/tb_multi_ch_read_requester.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_ch_read_requester.sv
// multi_ch_read_requester
//   N-channel hysteresis read requester. Each channel raises a pending flag
//   on a rising prog-full edge. When the optional starvation timeout is built,
//   a channel that has held data for too long also raises the flag. One
//   channel at a time is granted round-robin to the shared downstream reader.
//   The grant is released on a rising prog-empty edge of the granted channel,
//   or on true-empty when the grant was raised by a timeout.
//
//   Build option: define STARVATION_TIMEOUT_EN to build the per-channel
//   starvation counters. Without it, FIFO_EMPTY is ignored and
//   REQUEST_BY_TIMEOUT is always 0.
//
// Ports
//   CLK, RESETN          clock, synchronous active-low reset
//   PROGRAMMABLE_FULL    [NUM_CH]  per-channel prog-full flag
//   PROGRAMMABLE_EMPTY   [NUM_CH]  per-channel prog-empty flag
//   FIFO_EMPTY           [NUM_CH]  per-channel true-empty flag (timeout only)
//   READ_REQUEST         [NUM_CH]  one-hot grant or all-zero
//   READ_CH              [CH_W]    granted channel index, valid while READ_BUSY
//   READ_BUSY                      OR of READ_REQUEST
//   REQUEST_BY_TIMEOUT             current grant was raised by timeout

// Per-channel edge detect, pending flag and optional starvation counter.
module multi_ch_read_requester_ch #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic CLK,
    input  logic RESETN,
    input  logic prog_full,
    input  logic prog_empty,
    input  logic fifo_empty,
    input  logic release_grant,
    output logic empty_pe,
    output logic pending,
    output logic reason
);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);

    logic full_dly, empty_dly, full_pe, to_expire;

    assign full_pe  = prog_full  & ~full_dly;
    assign empty_pe = prog_empty & ~empty_dly;

`ifdef STARVATION_TIMEOUT_EN
    logic [TO_W-1:0] cnt;
    logic            cnt_run;

    // Counts only while data sits unserved; any pending state parks it at 0.
    assign cnt_run   = ~fifo_empty & ~pending;
    assign to_expire = cnt_run & (cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK) begin
        if (!RESETN)        cnt <= '0;
        else if (!cnt_run)  cnt <= '0;
        else if (to_expire) cnt <= '0;
        else                cnt <= cnt + TO_W'(1);
    end
`else
    logic unused_fifo_empty;
    assign unused_fifo_empty = fifo_empty;
    assign to_expire         = 1'b0;
`endif

    // A set on the same edge as release wins, so a refill coinciding with
    // the end of a grant is not lost. Reason 0 = prog-full, 1 = timeout.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            full_dly  <= 1'b0;
            empty_dly <= 1'b1;
            pending   <= 1'b0;
            reason    <= 1'b0;
        end else begin
            full_dly  <= prog_full;
            empty_dly <= prog_empty;
            if (full_pe) begin
                pending <= 1'b1;
                reason  <= 1'b0;
            end else if (to_expire) begin
                pending <= 1'b1;
                reason  <= 1'b1;
            end else if (release_grant) begin
                pending <= 1'b0;
                reason  <= 1'b0;
            end
        end
    end
endmodule

module multi_ch_read_requester #(
    parameter  int NUM_CH         = 4,
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int CH_W           = $clog2(NUM_CH)
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic [NUM_CH-1:0] PROGRAMMABLE_FULL,
    input  logic [NUM_CH-1:0] PROGRAMMABLE_EMPTY,
    input  logic [NUM_CH-1:0] FIFO_EMPTY,
    output logic [NUM_CH-1:0] READ_REQUEST,
    output logic [CH_W-1:0]   READ_CH,
    output logic              READ_BUSY,
    output logic              REQUEST_BY_TIMEOUT
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t            state, state_nxt;
    logic [NUM_CH-1:0] empty_pe, pending, reason, release_vec, req_nxt;
    logic [CH_W-1:0]   last_grant, last_nxt, ch_nxt, pick;
    logic [CH_W:0]     sum;
    logic              found, rel, rbt_q, rbt_nxt;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            multi_ch_read_requester_ch #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_ch (
                .CLK           (CLK),
                .RESETN        (RESETN),
                .prog_full     (PROGRAMMABLE_FULL[gi]),
                .prog_empty    (PROGRAMMABLE_EMPTY[gi]),
                .fifo_empty    (FIFO_EMPTY[gi]),
                .release_grant (release_vec[gi]),
                .empty_pe      (empty_pe[gi]),
                .pending       (pending[gi]),
                .reason        (reason[gi])
            );
        end
    endgenerate

    // Release condition for the currently granted channel.
`ifdef STARVATION_TIMEOUT_EN
    assign rel = empty_pe[READ_CH] | (reason[READ_CH] & FIFO_EMPTY[READ_CH]);
`else
    logic unused_reason;
    assign unused_reason = ^reason;
    assign rel           = empty_pe[READ_CH];
`endif

    // READ_REQUEST is the one-hot of the granted channel, so it doubles as
    // the per-channel release strobe.
    assign release_vec        = (state == GRANT && rel) ? READ_REQUEST : '0;
    assign READ_BUSY          = |READ_REQUEST;
    assign REQUEST_BY_TIMEOUT = rbt_q;

    // Round-robin search starting just after the last granted channel; the
    // last granted channel is therefore examined last.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            sum = {1'b0, last_grant} + (CH_W + 1)'(k);
            if (sum >= (CH_W + 1)'(NUM_CH)) sum = sum - (CH_W + 1)'(NUM_CH);
            if (!found && pending[sum[CH_W-1:0]]) begin
                found = 1'b1;
                pick  = sum[CH_W-1:0];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        req_nxt   = READ_REQUEST;
        ch_nxt    = READ_CH;
        rbt_nxt   = rbt_q;
        last_nxt  = last_grant;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = GRANT;
                    req_nxt   = {{(NUM_CH-1){1'b0}}, 1'b1} << pick;
                    ch_nxt    = pick;
                    last_nxt  = pick;
`ifdef STARVATION_TIMEOUT_EN
                    rbt_nxt   = reason[pick];
`else
                    rbt_nxt   = 1'b0;
`endif
                end
            end
            GRANT: begin
                if (rel) begin
                    state_nxt = IDLE;
                    req_nxt   = '0;
                    ch_nxt    = '0;
                    rbt_nxt   = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state        <= IDLE;
            READ_REQUEST <= '0;
            READ_CH      <= '0;
            rbt_q        <= 1'b0;
            last_grant   <= CH_W'(NUM_CH - 1);
        end else begin
            state        <= state_nxt;
            READ_REQUEST <= req_nxt;
            READ_CH      <= ch_nxt;
            rbt_q        <= rbt_nxt;
            last_grant   <= last_nxt;
        end
    end
endmodule

// File: tb/tb_multi_ch_read_requester.sv
// Directed bench for multi_ch_read_requester (NUM_CH=4, TIMEOUT_CYCLES=16).
// Inputs change 1 time unit after a rising edge and are sampled at the next
// rising edge; outputs are compared 1 time unit after each rising edge.
module tb_multi_ch_read_requester;
    logic       CLK = 1'b0;
    logic       RESETN;
    logic [3:0] PF, PE, FE;
    logic [3:0] READ_REQUEST;
    logic [1:0] READ_CH;
    logic       READ_BUSY, REQUEST_BY_TIMEOUT;
    logic [7:0] obs, e;
    int         vecs = 0;
    int         errs = 0;

    assign obs = {READ_REQUEST, READ_CH, READ_BUSY, REQUEST_BY_TIMEOUT};

    always #5 CLK = ~CLK;

    multi_ch_read_requester #(.NUM_CH(4), .TIMEOUT_CYCLES(16)) dut (
        .CLK                (CLK),
        .RESETN             (RESETN),
        .PROGRAMMABLE_FULL  (PF),
        .PROGRAMMABLE_EMPTY (PE),
        .FIFO_EMPTY         (FE),
        .READ_REQUEST       (READ_REQUEST),
        .READ_CH            (READ_CH),
        .READ_BUSY          (READ_BUSY),
        .REQUEST_BY_TIMEOUT (REQUEST_BY_TIMEOUT)
    );

    function automatic logic [7:0] ex(input logic [3:0] r, input logic [1:0] c,
                                      input logic b, input logic t);
        return {r, c, b, t};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESETN = 1'b0; PF = 4'b0000; PE = 4'b1111; FE = 4'b1111;
        tick();
        e = ex(4'b0000, 2'd0, 1'b0, 1'b0); vecs++;
        if (obs !== e) begin errs++; $display("FAIL reset_outputs got %b want %b", obs, e); end
        RESETN = 1'b1;
        tick();
    endtask

    // ch2 fills, is granted one edge after the prog-full edge, drains on
    // prog-empty at edge 9; prog-full held high must not re-request.
    task automatic test_single_grant();
        PF[2] = 1'b1; PE[2] = 1'b0;
        tick();  // E0
        e = ex(4'b0000, 2'd0, 1'b0, 1'b0); vecs++;
        if (obs !== e) begin errs++; $display("FAIL single_latency got %b want %b", obs, e); end
        tick();  // E1
        e = ex(4'b0100, 2'd2, 1'b1, 1'b0); vecs++;
        if (obs !== e) begin errs++; $display("FAIL single_grant got %b want %b", obs, e); end
        for (int i = 2; i <= 8; i++) tick();
        e = ex(4'b0100, 2'd2, 1'b1, 1'b0); vecs++;
        if (obs !== e) begin errs++; $display("FAIL single_hold got %b want %b", obs, e); end
        PE[2] = 1'b1;
        tick();  // E9
        e = ex(4'b0000, 2'd0, 1'b0, 1'b0); vecs++;
        if (obs !== e) begin errs++; $display("FAIL single_release got %b want %b", obs, e); end
        for (int i = 0; i < 4; i++) tick();
        e = ex(4'b0000, 2'd0, 1'b0, 1'b0); vecs++;
        if (obs !== e) begin errs++; $display("FAIL held_full_no_rerequest got %b want %b", obs, e); end
        PF[2] = 1'b0;
        tick();
    endtask

    // After reset last_grant=3, so ch0, ch1, ch3 in that order.
    task automatic test_round_robin();
        RESETN = 1'b0; PE = 4'b1111;
        tick();
        RESETN = 1'b1; PF = 4'b1011; PE = 4'b0100;
        tick();
        tick();
        e = ex(4'b0001, 2'd0, 1'b1, 1'b0); vecs++;
        if (obs !== e) begin errs++; $display("FAIL rr_first_ch0 got %b want %b", obs, e); end
        PE[0] = 1'b1;
        tick();
        e = ex(4'b0000, 2'd0, 1'b0, 1'b0); vecs++;
        if (obs !== e) begin errs++; $display("FAIL rr_gap_after_ch0 got %b want %b", obs, e); end
        tick();
        e = ex(4'b0010, 2'd1, 1'b1, 1'b0); vecs++;
        if (obs !== e) begin errs++; $display("FAIL rr_second_ch1 got %b want %b", obs, e); end
        PE[1] = 1'b1;
        tick();
        e = ex(4'b0000, 2'd0, 1'b0, 1'b0); vecs++;
        if (obs !== e) begin errs++; $display("FAIL rr_gap_after_ch1 got %b want %b", obs, e); end
        tick();
        e = ex(4'b1000, 2'd3, 1'b1, 1'b0); vecs++;
        if (obs !== e) begin errs++; $display("FAIL rr_third_ch3 got %b want %b", obs, e); end
        PE[3] = 1'b1;
        tick();
        tick();
        e = ex(4'b0000, 2'd0, 1'b0, 1'b0); vecs++;
        if (obs !== e) begin errs++; $display("FAIL rr_all_done got %b want %b", obs, e); end
        PF = 4'b0000;
        tick();
    endtask

    // ch1 granted; ch0 fills during the grant and ch1 refills on the very
    // edge that releases it. ch0 must go first, then ch1.
    task automatic test_repend_fairness();
        PF[1] = 1'b1; PE[1] = 1'b0;
        tick();
        tick();  // last_grant=3, search 0,1 -> ch1
        e = ex(4'b0010, 2'd1, 1'b1, 1'b0); vecs++;
        if (obs !== e) begin errs++; $display("FAIL repend_grant_ch1 got %b want %b", obs, e); end
        PF[1] = 1'b0; PF[0] = 1'b1; PE[0] = 1'b0;
        tick();
        PF[1] = 1'b1; PE[1] = 1'b1;  // refill coincides with release
        tick();
        e = ex(4'b0000, 2'd0, 1'b0, 1'b0); vecs++;
        if (obs !== e) begin errs++; $display("FAIL repend_release_ch1 got %b want %b", obs, e); end
        tick();
        e = ex(4'b0001, 2'd0, 1'b1, 1'b0); vecs++;
        if (obs !== e) begin errs++; $display("FAIL repend_fair_ch0 got %b want %b", obs, e); end
        PE[0] = 1'b1;
        tick();
        tick();
        e = ex(4'b0010, 2'd1, 1'b1, 1'b0); vecs++;
        if (obs !== e) begin errs++; $display("FAIL repend_setwins_ch1 got %b want %b", obs, e); end
        PE[1] = 1'b0;
        tick();
        PE[1] = 1'b1;
        tick();
        e = ex(4'b0000, 2'd0, 1'b0, 1'b0); vecs++;
        if (obs !== e) begin errs++; $display("FAIL repend_final_release got %b want %b", obs, e); end
        PF = 4'b0000;
        tick();
    endtask

    // Prog-full and prog-empty rise together on non-granted ch2: pending set.
    task automatic test_simul_edges();
        PF[3] = 1'b1; PE = 4'b0011;
        tick();
        tick();  // last_grant=1, search 2,3 -> ch3
        e = ex(4'b1000, 2'd3, 1'b1, 1'b0); vecs++;
        if (obs !== e) begin errs++; $display("FAIL simul_grant_ch3 got %b want %b", obs, e); end
        PF[2] = 1'b1; PE[2] = 1'b1;
        tick();
        PE[3] = 1'b1;
        tick();
        e = ex(4'b0000, 2'd0, 1'b0, 1'b0); vecs++;
        if (obs !== e) begin errs++; $display("FAIL simul_release_ch3 got %b want %b", obs, e); end
        tick();
        e = ex(4'b0100, 2'd2, 1'b1, 1'b0); vecs++;
        if (obs !== e) begin errs++; $display("FAIL simul_grant_ch2 got %b want %b", obs, e); end
        PE[2] = 1'b0;
        tick();
        PE[2] = 1'b1;
        tick();
        PF = 4'b0000;
        tick();
    endtask

    // Reset for one edge in the middle of a ch3 grant wipes the grant and
    // the pending flag.
    task automatic test_reset_mid_grant();
        PF[3] = 1'b1; PE[3] = 1'b0;
        tick();
        tick();  // last_grant=2 -> ch3
        e = ex(4'b1000, 2'd3, 1'b1, 1'b0); vecs++;
        if (obs !== e) begin errs++; $display("FAIL midreset_grant_ch3 got %b want %b", obs, e); end
        RESETN = 1'b0; PF = 4'b0000;
        tick();
        e = ex(4'b0000, 2'd0, 1'b0, 1'b0); vecs++;
        if (obs !== e) begin errs++; $display("FAIL midreset_outputs got %b want %b", obs, e); end
        RESETN = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        e = ex(4'b0000, 2'd0, 1'b0, 1'b0); vecs++;
        if (obs !== e) begin errs++; $display("FAIL midreset_no_regrant got %b want %b", obs, e); end
        PE = 4'b1111;
        tick();
    endtask

`ifdef STARVATION_TIMEOUT_EN
    // Counter reaches 15 at edge 15, expires at edge 16, grant after edge 17.
    task automatic test_timeout();
        FE[1] = 1'b0;
        for (int i = 1; i <= 16; i++) tick();
        e = ex(4'b0000, 2'd0, 1'b0, 1'b0); vecs++;
        if (obs !== e) begin errs++; $display("FAIL timeout_not_early got %b want %b", obs, e); end
        tick();
        e = ex(4'b0010, 2'd1, 1'b1, 1'b1); vecs++;
        if (obs !== e) begin errs++; $display("FAIL timeout_grant_ch1 got %b want %b", obs, e); end
        tick();
        e = ex(4'b0010, 2'd1, 1'b1, 1'b1); vecs++;
        if (obs !== e) begin errs++; $display("FAIL timeout_hold got %b want %b", obs, e); end
        FE[1] = 1'b1;
        tick();
        e = ex(4'b0000, 2'd0, 1'b0, 1'b0); vecs++;
        if (obs !== e) begin errs++; $display("FAIL timeout_release got %b want %b", obs, e); end
        tick();
    endtask
`else
    task automatic test_timeout();
        FE[1] = 1'b0;
        for (int i = 1; i <= 17; i++) tick();
        e = ex(4'b0000, 2'd0, 1'b0, 1'b0); vecs++;
        if (obs !== e) begin errs++; $display("FAIL no_timeout_17 got %b want %b", obs, e); end
        for (int i = 18; i <= 100; i++) tick();
        e = ex(4'b0000, 2'd0, 1'b0, 1'b0); vecs++;
        if (obs !== e) begin errs++; $display("FAIL no_timeout_100 got %b want %b", obs, e); end
        FE[1] = 1'b1;
        tick();
    endtask
`endif

    initial begin
        RESETN = 1'b0; PF = 4'b0000; PE = 4'b1111; FE = 4'b1111;
        tick();
        test_reset();
        test_single_grant();
        test_round_robin();
        test_repend_fairness();
        test_simul_edges();
        test_reset_mid_grant();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
